// File: rtl/dynaq_qtable_arbiter.sv
// dynaq_qtable_arbiter: shares the single q_table port between the real-experience
// training engine (port 0) and the Dyna-Q planning engine (port 1). Whole
// read-modify-write transactions are granted; port 0 has priority, port 1
// starvation is bounded by STARVE_LIMIT.
// Optional build macro DYNAQ_ARB_WATCHDOG_EN adds a grant-hold watchdog that
// forces the arbiter back to IDLE after TIMEOUT_CYCLES without a release.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no grant, qt_* buses driven 0, arbitration happens here
// S_GNT0 | port 0 owns the q_table port until release_0
// S_GNT1 | port 1 owns the q_table port until release_1
module dynaq_qtable_arbiter #(
  parameter int LOCATION_LENGTH = 5,
  parameter int DATA_LENGTH     = 16,
  parameter int READ_LATENCY    = 1,
  parameter int STARVE_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES  = 31
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_0,
  input  logic                       req_1,
  input  logic                       release_0,
  input  logic                       release_1,
  input  logic [LOCATION_LENGTH-1:0] r_addr_0,
  input  logic [LOCATION_LENGTH-1:0] r_addr_1,
  input  logic [LOCATION_LENGTH-1:0] w_addr_0,
  input  logic [LOCATION_LENGTH-1:0] w_addr_1,
  input  logic [1:0]                 action_0,
  input  logic [1:0]                 action_1,
  input  logic [DATA_LENGTH-1:0]     w_data_0,
  input  logic [DATA_LENGTH-1:0]     w_data_1,
  input  logic                       w_en_0,
  input  logic                       w_en_1,
  output logic                       gnt_0,
  output logic                       gnt_1,
  output logic                       r_valid_0,
  output logic                       r_valid_1,
  output logic [LOCATION_LENGTH-1:0] qt_r_address,
  output logic [LOCATION_LENGTH-1:0] qt_w_address,
  output logic [1:0]                 qt_action,
  output logic [DATA_LENGTH-1:0]     qt_w_data,
  output logic                       qt_w_en,
  output logic                       err_illegal_write,
  output logic                       timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  // The grant-age counter only has to reach the later of the read-valid
  // point and the watchdog limit; past that it simply saturates.
  localparam int CNT_MAX_I = (TIMEOUT_CYCLES > READ_LATENCY + 1) ?
                             TIMEOUT_CYCLES : READ_LATENCY + 1;
  localparam logic [7:0] CNT_MAX   = 8'(CNT_MAX_I);
  localparam logic [7:0] RV_AT     = 8'(READ_LATENCY);
  localparam logic [3:0] STARVE_MX = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  // cycles already spent in the current grant (0 in the first GNTx cycle)
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout_q, timeout_d;

`ifdef DYNAQ_ARB_WATCHDOG_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic wd_fire;
  assign wd_fire = (cnt_q == TO_LAST);
`else
  logic wd_fire;
  assign wd_fire = 1'b0;
`endif

  // Next-state, starvation tracking and watchdog decision
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_0 && req_1) begin
          if (starve_q == STARVE_MX) begin
            state_d  = S_GNT1;
            starve_d = 4'd0;
          end else begin
            state_d  = S_GNT0;
            starve_d = starve_q + 4'd1;
          end
        end else if (req_0) begin
          state_d  = S_GNT0;
          starve_d = 4'd0;
        end else if (req_1) begin
          state_d  = S_GNT1;
          starve_d = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      S_GNT0: begin
        if (release_0) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_GNT1: begin
        if (release_1) begin
          state_d = S_IDLE;
        end else if (wd_fire) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant-age counter restarts on every new grant and saturates
  always_comb begin
    cnt_d = 8'd0;
    if (state_d != S_IDLE && state_d == state_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end
  end

  assign gnt_0 = (state_q == S_GNT0);
  assign gnt_1 = (state_q == S_GNT1);

  // A write strobe from a port that does not own the table is a protocol error
  always_comb begin
    err_d = err_q | (w_en_0 & ~gnt_0) | (w_en_1 & ~gnt_1);
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      starve_q  <= 4'd0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign err_illegal_write = err_q;
  assign timeout           = timeout_q;

  // Read-valid fires once per grant because the age counter passes RV_AT once
  always_comb begin
    r_valid_0 = gnt_0 && (cnt_q == RV_AT);
    r_valid_1 = gnt_1 && (cnt_q == RV_AT);
  end

  // Route the owning port to q_table; IDLE parks every bus at 0
  always_comb begin
    qt_r_address = '0;
    qt_w_address = '0;
    qt_action    = '0;
    qt_w_data    = '0;
    qt_w_en      = 1'b0;
    case (state_q)
      S_GNT0: begin
        qt_r_address = r_addr_0;
        qt_w_address = w_addr_0;
        qt_action    = action_0;
        qt_w_data    = w_data_0;
        qt_w_en      = w_en_0;
      end
      S_GNT1: begin
        qt_r_address = r_addr_1;
        qt_w_address = w_addr_1;
        qt_action    = action_1;
        qt_w_data    = w_data_1;
        qt_w_en      = w_en_1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dynaq_qtable_arbiter.sv
// Directed bench for dynaq_qtable_arbiter (READ_LATENCY 1, STARVE_LIMIT 4,
// TIMEOUT_CYCLES 5). Inputs change 2 time units after a rising edge, outputs
// are sampled on the falling edge.
module tb_dynaq_qtable_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_0, req_1, release_0, release_1;
  logic [4:0]  r_addr_0, r_addr_1, w_addr_0, w_addr_1;
  logic [1:0]  action_0, action_1;
  logic [15:0] w_data_0, w_data_1;
  logic        w_en_0, w_en_1;
  logic        gnt_0, gnt_1, r_valid_0, r_valid_1;
  logic [4:0]  qt_r_address, qt_w_address;
  logic [1:0]  qt_action;
  logic [15:0] qt_w_data;
  logic        qt_w_en, err_illegal_write, timeout;

  int n_vec = 0;
  int n_err = 0;

  dynaq_qtable_arbiter #(
    .LOCATION_LENGTH(5), .DATA_LENGTH(16), .READ_LATENCY(1),
    .STARVE_LIMIT(4), .TIMEOUT_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1),
    .release_0(release_0), .release_1(release_1),
    .r_addr_0(r_addr_0), .r_addr_1(r_addr_1),
    .w_addr_0(w_addr_0), .w_addr_1(w_addr_1),
    .action_0(action_0), .action_1(action_1),
    .w_data_0(w_data_0), .w_data_1(w_data_1),
    .w_en_0(w_en_0), .w_en_1(w_en_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .r_valid_0(r_valid_0), .r_valid_1(r_valid_1),
    .qt_r_address(qt_r_address), .qt_w_address(qt_w_address),
    .qt_action(qt_action), .qt_w_data(qt_w_data), .qt_w_en(qt_w_en),
    .err_illegal_write(err_illegal_write), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got expired want finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] exp_g;
    int rv_cnt;
    int drops;

    reset = 1'b1;
    req_0 = 0; req_1 = 0; release_0 = 0; release_1 = 0;
    r_addr_0 = 0; r_addr_1 = 0; w_addr_0 = 0; w_addr_1 = 0;
    action_0 = 0; action_1 = 0; w_data_0 = 0; w_data_1 = 0;
    w_en_0 = 0; w_en_1 = 0;

    // reset state
    cyc(); cyc(); #3;
    chk("rst_gnt", {gnt_1, gnt_0}, 2'b00);
    chk("rst_rvalid", {r_valid_1, r_valid_0}, 2'b00);
    chk("rst_qt", {qt_w_en, qt_r_address, qt_w_address, qt_action, qt_w_data}, 0);
    chk("rst_flags", {err_illegal_write, timeout}, 2'b00);

    // single port-1 read transaction
    reset = 1'b0;
    req_1 = 1; r_addr_1 = 5'd7;
    cyc(); req_1 = 0; #3;
    chk("p1_gnt", {gnt_1, gnt_0}, 2'b10);
    chk("p1_raddr", qt_r_address, 5'd7);
    chk("p1_rv_early", r_valid_1, 1'b0);
    cyc(); release_1 = 1; #3;
    chk("p1_rv", {r_valid_1, gnt_1}, 2'b11);
    cyc(); release_1 = 0; #3;
    chk("p1_done", {gnt_1, r_valid_1}, 2'b00);
    chk("p1_idle_raddr", qt_r_address, 5'd0);

    // both requesting, 3-cycle transactions: order 0,0,0,0,1 repeating
    req_0 = 1; req_1 = 1;
    for (int k = 0; k < 10; k++) begin
      exp_g = ((k % 5) == 4) ? 2'b10 : 2'b01;
      cyc(); #3;
      chk($sformatf("starve_gnt%0d", k), {gnt_1, gnt_0}, exp_g);
      cyc(); #3;
      chk($sformatf("starve_rv%0d", k), {r_valid_1, r_valid_0}, exp_g);
      cyc(); release_0 = exp_g[0]; release_1 = exp_g[1]; #3;
      cyc(); release_0 = 0; release_1 = 0; #3;
      chk($sformatf("starve_bubble%0d", k), {gnt_1, gnt_0}, 2'b00);
    end
    req_0 = 0; req_1 = 0;

    // write forwarding from port 0, illegal write from port 1
    cyc();
    req_0 = 1;
    cyc(); req_0 = 0;
    w_addr_0 = 5'd12; action_0 = 2'd2; w_data_0 = 16'h0100;
    w_en_0 = 1; w_en_1 = 1; release_1 = 1;
    #3;
    chk("wr_en", qt_w_en, 1'b1);
    chk("wr_addr", qt_w_address, 5'd12);
    chk("wr_action", qt_action, 2'd2);
    chk("wr_data", qt_w_data, 16'h0100);
    chk("wr_err_pre", err_illegal_write, 1'b0);
    cyc(); w_en_0 = 0; release_1 = 0; #3;
    chk("rel1_ignored", gnt_0, 1'b1);
    chk("wr_err_set", err_illegal_write, 1'b1);
    chk("wr_no_fwd_p1", qt_w_en, 1'b0);
    cyc(); w_en_1 = 0; w_en_0 = 1; w_data_0 = 16'h1234; release_0 = 1; #3;
    chk("wr_with_rel", {qt_w_en, qt_w_data}, {1'b1, 16'h1234});
    cyc(); w_en_0 = 0; release_0 = 0; #3;
    chk("wr_after", {gnt_0, qt_w_en, qt_w_address}, 0);
    chk("wr_err_sticky", err_illegal_write, 1'b1);

    // port 0 never releases
    req_0 = 1;
    cyc(); req_0 = 0;
    rv_cnt = 0;
    drops = 0;
`ifdef DYNAQ_ARB_WATCHDOG_EN
    for (int i = 0; i < 5; i++) begin
      #3;
      if (!gnt_0) drops++;
      if (timeout) drops++;
      if (r_valid_0) rv_cnt++;
      cyc();
    end
    chk("wd_held5", drops, 0);
    chk("wd_rv_once", rv_cnt, 1);
    #3;
    chk("wd_fire", {timeout, gnt_0}, 2'b10);
    cyc(); #3;
    chk("wd_pulse_end", timeout, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      #3;
      if (!gnt_0) drops++;
      if (r_valid_0) rv_cnt++;
      cyc();
    end
    chk("hold100", drops, 0);
    chk("hold_rv_once", rv_cnt, 1);
    chk("hold_no_timeout", timeout, 1'b0);
    release_0 = 1;
    cyc(); release_0 = 0; #3;
    chk("hold_released", gnt_0, 1'b0);
`endif

    // reset in the middle of a port-1 write
    req_1 = 1;
    cyc(); req_1 = 0; w_en_1 = 1; #3;
    chk("rst_mid_wen", {qt_w_en, gnt_1}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("rst_async", {qt_w_en, gnt_1}, 2'b00);
    chk("rst_err_clr", err_illegal_write, 1'b0);
    req_0 = 1; w_en_1 = 0;
    cyc(); reset = 1'b0; #3;
    chk("post_rst_idle", gnt_0, 1'b0);
    cyc(); req_0 = 0; #3;
    chk("post_rst_gnt0", gnt_0, 1'b1);
    release_0 = 1;
    cyc(); release_0 = 0; #3;
    chk("post_rst_rel", gnt_0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dynaq_qtable_arbiter.md
# dynaq_qtable_arbiter

Shares the single Q-table port (one read address, one write address/action/data/enable) between two requesters: the real-experience training engine (port 0) and the Dyna-Q planning/model-replay engine (port 1). Sits between those two engines and `q_table` in the Dyna-Q top level. Grants whole read-modify-write transactions, gives port 0 priority, bounds port 1 starvation, and optionally recovers from a requester that never releases.

## Interface
Parameters:
- `LOCATION_LENGTH`, 5: Q-table state address width.
- `DATA_LENGTH`, 16: Q-value width.
- `READ_LATENCY`, 1: cycles from address driven to `q_table` read data valid (0..3).
- `STARVE_LIMIT`, 4: consecutive port-0 grants allowed while port 1 waits (1..15).
- `TIMEOUT_CYCLES`, 31: maximum grant hold without release (watchdog build only, 2..255).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_0` / `req_1`  in  1  transaction request, level, held until granted.
- `release_0` / `release_1`  in  1  one-cycle end-of-transaction pulse from the granted requester.
- `r_addr_0` / `r_addr_1`  in  LOCATION_LENGTH  read state address.
- `w_addr_0` / `w_addr_1`  in  LOCATION_LENGTH  write state address.
- `action_0` / `action_1`  in  2  write action index.
- `w_data_0` / `w_data_1`  in  DATA_LENGTH  write Q-value.
- `w_en_0` / `w_en_1`  in  1  write strobe.
- `gnt_0` / `gnt_1`  out  1  grant, registered, one-hot or zero.
- `r_valid_0` / `r_valid_1`  out  1  one-cycle pulse: shared `q_table` read data is valid for this requester.
- `qt_r_address`  out  LOCATION_LENGTH  to `q_table` read address.
- `qt_w_address`  out  LOCATION_LENGTH  to `q_table` write address.
- `qt_action`  out  2  to `q_table` action.
- `qt_w_data`  out  DATA_LENGTH  to `q_table` write data.
- `qt_w_en`  out  1  to `q_table` write enable.
- `err_illegal_write`  out  1  sticky: a non-granted port asserted `w_en_x`.
- `timeout`  out  1  one-cycle watchdog pulse.

## Operation
- FSM states IDLE, GNT0, GNT1.
- IDLE: arbitrate on `req_0`/`req_1`. Only one asserted: go to its GNT state. Both asserted: GNT0, unless `starve_cnt == STARVE_LIMIT`, then GNT1. Neither asserted: stay.
- GNTx: hold until `release_x` is sampled, then IDLE. Re-arbitration always happens in IDLE, so there is one bubble cycle between transactions.
- `starve_cnt` (4 bits): increments on each entry to GNT0 while `req_1` is high. Clears on entry to GNT1, or when arbitration in IDLE sees `req_1` low. Saturates at STARVE_LIMIT.
- Output mux, combinational from the registered state:
  - GNT0 routes port-0 address/action/data.
  - GNT1 routes port 1.
  - IDLE drives all `qt_*` buses 0.
  - `qt_w_en = w_en_x & gnt_x` only.
- Non-granted `w_en_x` is never forwarded; it sets `err_illegal_write`, which clears only on reset.
- `release_x` from a non-granted port is ignored.
- `r_valid_x` pulses exactly once per grant, READ_LATENCY cycles after the first GNTx cycle (READ_LATENCY = 0: in the first GNTx cycle).
- If release occurs before the pulse is due, the pulse is suppressed.
- Reset values: state IDLE; `gnt_*`, `r_valid_*`, `qt_*`, `err_illegal_write`, `timeout`, and all counters 0.
- Reset mid-transaction: `qt_w_en` drops asynchronously and no write is issued.

## Timing
- `req_x` sampled at edge N in IDLE: `gnt_x` high from N+1.
- `release_x` sampled at edge M: `gnt_x` low from M+1. Earliest next grant is M+2.
- A write with `w_en_x` and `release_x` in the same cycle is forwarded that cycle.
- Same requester asserting `release_x` and keeping `req_x` high: IDLE for one cycle, then re-arbitration.

## Configuration
- `DYNAQ_ARB_WATCHDOG_EN` defined:
  - `hold_cnt` counts GNTx cycles.
  - When `hold_cnt` reaches TIMEOUT_CYCLES with no release, force IDLE next cycle, pulse `timeout` for one cycle, and suppress the pending `r_valid_x`.
  - A release in the same cycle as the limit takes precedence, and `timeout` stays 0.
- Undefined: no counter, `timeout` tied 0, grant held indefinitely.

## Test plan
- `req_1` only, `r_addr_1` = 7, READ_LATENCY = 1 -> `gnt_1` one cycle after the request, `qt_r_address` = 7, `r_valid_1` pulses on the second GNT1 cycle.
- Both requests held continuously, each transaction 3 cycles, STARVE_LIMIT = 4 -> grant order 0,0,0,0,1,0,0,0,0,1, with one IDLE cycle between grants.
- GNT0 with `w_en_0` = 1, `w_addr_0` = 12, `action_0` = 2, `w_data_0` = 16'h0100, while `w_en_1` = 1 -> `qt_w_en`/`qt_w_address`/`qt_action`/`qt_w_data` = 1/12/2/16'h0100, and `err_illegal_write` rises and stays set.
- Watchdog build, TIMEOUT_CYCLES = 5, port 0 never releases -> `timeout` pulses and `gnt_0` drops after 5 grant cycles. Non-watchdog build: `gnt_0` stays high for 100 cycles.
- `reset` asserted mid-GNT1 with `w_en_1` high -> `qt_w_en` and `gnt_1` go 0 immediately. After reset release with `req_0` high, `gnt_0` asserts one cycle later.
